// File: rtl/toy_alu_pipe.sv
// toy_alu_pipe: registered integer execute stage (OP/OP_IMM/LUI/AUIPC/JAL/JALR/BRANCH) with one output slot.
// Define TOY_ALU_MUL_EN to add the iterative shift-add MUL; otherwise M-encodings report illegal.
module toy_alu_pipe #(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int INST_IDX_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [4:0]                  in_opcode,
  input  logic [2:0]                  in_funct3,
  input  logic                        in_f7b5,
  input  logic                        in_f7b0,
  input  logic                        in_is_reg,
  input  logic                        in_cext,
  input  logic [XLEN-1:0]             in_rs1,
  input  logic [XLEN-1:0]             in_rs2,
  input  logic [XLEN-1:0]             in_imm,
  input  logic [ADDR_WIDTH-1:0]       in_pc,
  input  logic                        in_rd_en,
  input  logic [PHY_REG_ID_WIDTH-1:0] in_rd,
  input  logic [INST_IDX_WIDTH-1:0]   in_inst_id,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic                        out_rd_wr_en,
  output logic [PHY_REG_ID_WIDTH-1:0] out_rd,
  output logic [XLEN-1:0]             out_rd_data,
  output logic [INST_IDX_WIDTH-1:0]   out_inst_id,
  output logic                        out_pc_release_en,
  output logic                        out_pc_update_en,
  output logic [ADDR_WIDTH-1:0]       out_pc_val,
  output logic [ADDR_WIDTH-1:0]       out_nxt_pc,
  output logic                        out_illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  logic [XLEN-1:0]       op_b;
  logic [XLEN-1:0]       alu_res;
  logic [XLEN-1:0]       res_data;
  logic [XLEN-1:0]       jalr_sum;
  logic [SHW-1:0]        shamt;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic [ADDR_WIDTH-1:0] br_tgt;
  logic [ADDR_WIDTH-1:0] jalr_tgt;
  logic [ADDR_WIDTH-1:0] res_pc_val;
  logic [ADDR_WIDTH-1:0] res_nxt_pc;
  logic                  br_taken;
  logic                  is_mext;
  logic                  res_release;
  logic                  res_update;
  logic                  res_illegal;
  logic                  accept;
  logic                  take_single;

  assign op_b     = in_is_reg ? in_rs2 : in_imm;
  assign shamt    = op_b[SHW-1:0];
  assign step     = in_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
  assign pc_seq   = in_pc + step;
  assign br_tgt   = in_pc + in_imm[ADDR_WIDTH-1:0];
  assign jalr_sum = in_rs1 + in_imm;
  assign jalr_tgt = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
  assign is_mext  = (in_opcode == OPC_OP) & in_f7b0;

  always_comb begin
    alu_res = '0;
    case (in_funct3)
      3'b000:  alu_res = (in_is_reg & in_f7b5) ? in_rs1 - op_b : in_rs1 + op_b;
      3'b001:  alu_res = in_rs1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(op_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, in_rs1 < op_b};
      3'b100:  alu_res = in_rs1 ^ op_b;
      3'b101:  alu_res = in_f7b5 ? $unsigned($signed(in_rs1) >>> shamt) : in_rs1 >> shamt;
      3'b110:  alu_res = in_rs1 | op_b;
      default: alu_res = in_rs1 & op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (in_funct3)
      3'b000:  br_taken = (in_rs1 == in_rs2);
      3'b001:  br_taken = (in_rs1 != in_rs2);
      3'b100:  br_taken = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  br_taken = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  br_taken = (in_rs1 < in_rs2);
      3'b111:  br_taken = (in_rs1 >= in_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // M-encodings that reach this path are always illegal: a legal MUL goes to the FSM instead.
  always_comb begin
    res_data    = '0;
    res_release = 1'b0;
    res_update  = 1'b0;
    res_pc_val  = '0;
    res_nxt_pc  = pc_seq;
    res_illegal = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        if (is_mext) res_illegal = 1'b1;
        else         res_data    = alu_res;
      end
      OPC_OP_IMM: res_data = alu_res;
      OPC_LUI:    res_data = in_imm;
      OPC_AUIPC:  res_data = XLEN'(in_pc) + in_imm;
      OPC_JAL: begin
        res_data    = XLEN'(pc_seq);
        res_release = 1'b1;
        res_update  = 1'b1;
        res_pc_val  = br_tgt;
        res_nxt_pc  = br_tgt;
      end
      OPC_JALR: begin
        res_data    = XLEN'(pc_seq);
        res_release = 1'b1;
        res_update  = 1'b1;
        res_pc_val  = jalr_tgt;
        res_nxt_pc  = jalr_tgt;
      end
      OPC_BRANCH: begin
        res_release = 1'b1;
        res_update  = br_taken;
        res_pc_val  = br_tgt;
        res_nxt_pc  = br_taken ? br_tgt : pc_seq;
      end
      default: res_illegal = 1'b1;
    endcase
  end

`ifdef TOY_ALU_MUL_EN
  // state  | meaning
  // S_IDLE | accepting requests
  // S_MUL  | shift-add iteration, mul_cnt counts XLEN-1 down to 0
  // S_DONE | load product into output slot, hold until drained
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                      state;
  logic [SHW-1:0]              mul_cnt;
  logic [XLEN-1:0]             mul_mcand;
  logic [XLEN-1:0]             mul_mplier;
  logic [XLEN-1:0]             mul_acc;
  logic [XLEN-1:0]             mul_sum;
  logic                        mul_rd_en;
  logic [PHY_REG_ID_WIDTH-1:0] mul_rd;
  logic [INST_IDX_WIDTH-1:0]   mul_id;
  logic [ADDR_WIDTH-1:0]       mul_nxt;
  logic                        take_mul;

  assign in_rdy      = ~flush & (state == S_IDLE) & (~out_vld | out_rdy);
  assign take_mul    = accept & is_mext & (in_funct3 == 3'b000);
  assign take_single = accept & ~take_mul;
  assign mul_sum     = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`else
  assign in_rdy      = ~flush & (~out_vld | out_rdy);
  assign take_single = accept;
`endif

  assign accept = in_vld & in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld           <= 1'b0;
      out_rd_wr_en      <= 1'b0;
      out_rd            <= '0;
      out_rd_data       <= '0;
      out_inst_id       <= '0;
      out_pc_release_en <= 1'b0;
      out_pc_update_en  <= 1'b0;
      out_pc_val        <= '0;
      out_nxt_pc        <= '0;
      out_illegal       <= 1'b0;
`ifdef TOY_ALU_MUL_EN
      state      <= S_IDLE;
      mul_cnt    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_rd_en  <= 1'b0;
      mul_rd     <= '0;
      mul_id     <= '0;
      mul_nxt    <= '0;
`endif
    end else if (flush) begin
      out_vld <= 1'b0;
`ifdef TOY_ALU_MUL_EN
      state   <= S_IDLE;
      mul_cnt <= '0;
`endif
    end else begin
      if (out_vld && out_rdy) out_vld <= 1'b0;
      if (take_single) begin
        out_vld           <= 1'b1;
        out_rd_wr_en      <= in_rd_en;
        out_rd            <= in_rd;
        out_rd_data       <= res_data;
        out_inst_id       <= in_inst_id;
        out_pc_release_en <= res_release;
        out_pc_update_en  <= res_update;
        out_pc_val        <= res_pc_val;
        out_nxt_pc        <= res_nxt_pc;
        out_illegal       <= res_illegal;
      end
`ifdef TOY_ALU_MUL_EN
      case (state)
        S_IDLE: begin
          if (take_mul) begin
            state      <= S_MUL;
            mul_cnt    <= SHW'(XLEN-1);
            mul_mcand  <= in_rs1;
            mul_mplier <= in_rs2;
            mul_acc    <= '0;
            mul_rd_en  <= in_rd_en;
            mul_rd     <= in_rd;
            mul_id     <= in_inst_id;
            mul_nxt    <= pc_seq;
          end
        end
        S_MUL: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          if (mul_cnt == '0) state   <= S_DONE;
          else               mul_cnt <= mul_cnt - SHW'(1);
        end
        S_DONE: begin
          if (!out_vld) begin
            out_vld           <= 1'b1;
            out_rd_wr_en      <= mul_rd_en;
            out_rd            <= mul_rd;
            out_rd_data       <= mul_acc;
            out_inst_id       <= mul_id;
            out_pc_release_en <= 1'b0;
            out_pc_update_en  <= 1'b0;
            out_pc_val        <= '0;
            out_nxt_pc        <= mul_nxt;
            out_illegal       <= 1'b0;
          end else if (out_rdy) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_toy_alu_pipe.sv
// Bench for toy_alu_pipe (XLEN=32): directed vector table, random ops against a behavioural
// model with random backpressure, plus backpressure, flush, async reset and (if enabled) MUL sequences.
module tb_toy_alu_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int RW   = 6;
  localparam int IW   = 8;

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_OP_32  = 5'b01110;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;

  logic            clk = 1'b0;
  logic            rst, flush, in_vld, in_rdy;
  logic [4:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_f7b5, in_f7b0, in_is_reg, in_cext;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm;
  logic [AW-1:0]   in_pc;
  logic            in_rd_en;
  logic [RW-1:0]   in_rd;
  logic [IW-1:0]   in_inst_id;
  logic            out_vld, out_rdy, out_rd_wr_en;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_rd_data;
  logic [IW-1:0]   out_inst_id;
  logic            out_pc_release_en, out_pc_update_en;
  logic [AW-1:0]   out_pc_val, out_nxt_pc;
  logic            out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  toy_alu_pipe #(.XLEN(XLEN), .ADDR_WIDTH(AW), .PHY_REG_ID_WIDTH(RW), .INST_IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_f7b0(in_f7b0),
    .in_is_reg(in_is_reg), .in_cext(in_cext), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd_en(in_rd_en), .in_rd(in_rd),
    .in_inst_id(in_inst_id), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_rd_wr_en(out_rd_wr_en), .out_rd(out_rd), .out_rd_data(out_rd_data),
    .out_inst_id(out_inst_id), .out_pc_release_en(out_pc_release_en),
    .out_pc_update_en(out_pc_update_en), .out_pc_val(out_pc_val),
    .out_nxt_pc(out_nxt_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, f7b0, is_reg, cext;
    logic [31:0] rs1, rs2, imm, pc;
    logic        rd_en;
    logic [5:0]  rd;
    logic [7:0]  id;
    logic [31:0] e_data;
    logic        e_rel, e_upd;
    logic [31:0] e_pcval, e_nxt;
    logic        e_ill;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] opcs [11];

  function automatic vec_t mk(input string nm, input logic [4:0] opc, input logic [2:0] f3,
                              input logic f7b5, input logic f7b0, input logic is_reg,
                              input logic cext, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [31:0] e_data, input logic e_rel, input logic e_upd,
                              input logic [31:0] e_pcval, input logic [31:0] e_nxt,
                              input logic e_ill);
    vec_t r;
    r.name = nm; r.opc = opc; r.f3 = f3; r.f7b5 = f7b5; r.f7b0 = f7b0; r.is_reg = is_reg;
    r.cext = cext; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc;
    r.rd_en = 1'b1; r.rd = '0; r.id = '0;
    r.e_data = e_data; r.e_rel = e_rel; r.e_upd = e_upd; r.e_pcval = e_pcval;
    r.e_nxt = e_nxt; r.e_ill = e_ill;
    return r;
  endfunction

  // Behavioural reference: instruction semantics in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] b, step;
    int          sh;
    logic        taken;
    r = v;
    step = v.cext ? 32'd2 : 32'd4;
    b = v.is_reg ? v.rs2 : v.imm;
    sh = int'(b % 32);
    taken = 1'b0;
    r.e_data = 0; r.e_rel = 0; r.e_upd = 0; r.e_pcval = 0; r.e_nxt = v.pc + step; r.e_ill = 0;
    if (v.opc == OPC_OP && v.f7b0) r.e_ill = 1'b1;
    else if (v.opc == OPC_OP || v.opc == OPC_OP_IMM) begin
      case (v.f3)
        3'd0: r.e_data = (v.is_reg && v.f7b5) ? v.rs1 - b : v.rs1 + b;
        3'd1: r.e_data = v.rs1 << sh;
        3'd2: r.e_data = ($signed(v.rs1) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r.e_data = (v.rs1 < b) ? 32'd1 : 32'd0;
        3'd4: r.e_data = v.rs1 ^ b;
        3'd5: r.e_data = v.f7b5 ? 32'($signed(v.rs1) >>> sh) : v.rs1 >> sh;
        3'd6: r.e_data = v.rs1 | b;
        default: r.e_data = v.rs1 & b;
      endcase
    end else if (v.opc == OPC_LUI) r.e_data = v.imm;
    else if (v.opc == OPC_AUIPC) r.e_data = v.pc + v.imm;
    else if (v.opc == OPC_JAL || v.opc == OPC_JALR) begin
      r.e_data = v.pc + step; r.e_rel = 1; r.e_upd = 1;
      r.e_pcval = (v.opc == OPC_JAL) ? v.pc + v.imm : (v.rs1 + v.imm) & 32'hFFFF_FFFE;
      r.e_nxt = r.e_pcval;
    end else if (v.opc == OPC_BRANCH) begin
      case (v.f3)
        3'd0: taken = (v.rs1 == v.rs2);
        3'd1: taken = (v.rs1 != v.rs2);
        3'd4: taken = ($signed(v.rs1) < $signed(v.rs2));
        3'd5: taken = ($signed(v.rs1) >= $signed(v.rs2));
        3'd6: taken = (v.rs1 < v.rs2);
        3'd7: taken = (v.rs1 >= v.rs2);
        default: taken = 1'b0;
      endcase
      r.e_rel = 1; r.e_upd = taken; r.e_pcval = v.pc + v.imm;
      r.e_nxt = taken ? r.e_pcval : v.pc + step;
    end else r.e_ill = 1'b1;
    return r;
  endfunction

  function automatic vec_t rand_vec(input int i);
    vec_t v;
    v.name = "rnd";
    v.opc = opcs[$urandom_range(0, 10)];
    v.f3 = 3'($urandom);
    v.is_reg = (v.opc == OPC_OP);
    v.f7b0 = (v.opc == OPC_OP) && ($urandom_range(0, 5) == 0);
`ifdef TOY_ALU_MUL_EN
    if (v.f7b0 && v.f3 == 3'd0) v.f7b0 = 1'b0;
`endif
    v.f7b5 = (v.f3 == 3'd0 || v.f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
    v.cext = 1'($urandom_range(0, 1));
    v.rs1 = $urandom;
    v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
    v.imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
    v.pc = $urandom & 32'hFFFF_FFFE;
    v.rd_en = 1'($urandom_range(0, 1));
    v.rd = 6'($urandom);
    v.id = 8'(i);
    return model(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.opc; in_funct3 = v.f3; in_f7b5 = v.f7b5; in_f7b0 = v.f7b0;
    in_is_reg = v.is_reg; in_cext = v.cext; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_imm = v.imm; in_pc = v.pc; in_rd_en = v.rd_en; in_rd = v.rd; in_inst_id = v.id;
  endtask

  task automatic check_fields(input vec_t v);
    chk({v.name, " data"},   out_rd_data, v.e_data);
    chk({v.name, " rel"},    out_pc_release_en, v.e_rel);
    chk({v.name, " upd"},    out_pc_update_en, v.e_upd);
    chk({v.name, " pc_val"}, out_pc_val, v.e_pcval);
    chk({v.name, " nxt_pc"}, out_nxt_pc, v.e_nxt);
    chk({v.name, " ill"},    out_illegal, v.e_ill);
    chk({v.name, " rd"},     out_rd, v.rd);
    chk({v.name, " id"},     out_inst_id, v.id);
    chk({v.name, " rd_en"},  out_rd_wr_en, v.rd_en);
  endtask

  task automatic check_out(input vec_t v);
    chk({v.name, " vld"}, out_vld, 1'b1);
    check_fields(v);
  endtask

`ifdef TOY_ALU_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id);
    vec_t        v;
    int          cyc;
    logic [63:0] p;
    v = mk("mul", OPC_OP, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, a, b, 0, 32'h600, 0, 0, 0, 0, 32'h604, 0);
    v.id = id; v.rd = 6'd9;
    p = 64'(a) * 64'(b);
    v.e_data = p[31:0];
    drive(v); in_vld = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1; in_vld = 1'b0;
    chk("mul busy in_rdy", in_rdy, 1'b0);
    cyc = 0;
    while (!out_vld && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("mul latency", 64'(cyc), 64'(XLEN + 1));
    check_out(v);
    @(posedge clk); #1;
    chk("mul drained vld", out_vld, 1'b0);
    chk("mul idle in_rdy", in_rdy, 1'b1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, a, b;
    logic exp_vld, exp_rdy, acc, seen;

    opcs = '{OPC_OP, OPC_OP, OPC_OP_IMM, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
             OPC_JALR, OPC_BRANCH, OPC_OP_32, OPC_LOAD};

    tbl.push_back(mk("add",    OPC_OP, 0, 0, 0, 1, 0, 7, 5, 0, 32'h40, 12, 0, 0, 0, 32'h44, 0));
    tbl.push_back(mk("sub",    OPC_OP, 0, 1, 0, 1, 0, 7, 5, 0, 32'h44, 2, 0, 0, 0, 32'h48, 0));
    tbl.push_back(mk("addi_b5", OPC_OP_IMM, 0, 1, 0, 0, 0, 7, 0, 5, 0, 12, 0, 0, 0, 4, 0));
    tbl.push_back(mk("srai",   OPC_OP_IMM, 5, 1, 0, 0, 0, 32'h8000_0000, 0, 4, 0, 32'hF800_0000, 0, 0, 0, 4, 0));
    tbl.push_back(mk("srli",   OPC_OP_IMM, 5, 0, 0, 0, 0, 32'h8000_0000, 0, 4, 0, 32'h0800_0000, 0, 0, 0, 4, 0));
    tbl.push_back(mk("sll",    OPC_OP, 1, 0, 0, 1, 0, 1, 32'h25, 0, 0, 32'h20, 0, 0, 0, 4, 0));
    tbl.push_back(mk("slt",    OPC_OP, 2, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 0, 4, 0));
    tbl.push_back(mk("sltu",   OPC_OP, 3, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk("bltu",   OPC_BRANCH, 6, 0, 0, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100, 0, 1, 1, 32'hF8, 32'hF8, 0));
    tbl.push_back(mk("bge_nt", OPC_BRANCH, 5, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 0, 1, 0, 32'hF8, 32'h104, 0));
    tbl.push_back(mk("bge_ntc", OPC_BRANCH, 5, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 0, 1, 0, 32'hF8, 32'h102, 0));
    tbl.push_back(mk("lui",    OPC_LUI, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5000, 32'h8, 32'h1234_5000, 0, 0, 0, 32'hC, 0));
    tbl.push_back(mk("auipc",  OPC_AUIPC, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 32'h1000, 32'h3000, 0, 0, 0, 32'h1004, 0));
    tbl.push_back(mk("jal",    OPC_JAL, 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h200, 32'h204, 1, 1, 32'h240, 32'h240, 0));
    tbl.push_back(mk("jalr_c", OPC_JALR, 0, 0, 0, 0, 1, 32'h301, 0, 32'h10, 32'h80, 32'h82, 1, 1, 32'h310, 32'h310, 0));
    tbl.push_back(mk("op32",   OPC_OP_32, 0, 0, 0, 1, 0, 3, 4, 0, 32'h20, 0, 0, 0, 0, 32'h24, 1));
    tbl.push_back(mk("mulh",   OPC_OP, 1, 0, 1, 1, 0, 5, 6, 0, 32'h30, 0, 0, 0, 0, 32'h34, 1));
`ifndef TOY_ALU_MUL_EN
    tbl.push_back(mk("mul_off", OPC_OP, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 3, 0, 32'h50, 0, 0, 0, 0, 32'h54, 1));
`endif

    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    drive(tbl[0]);
    #12;
    chk("rst out_vld", out_vld, 1'b0);
    chk("rst data", out_rd_data, 0);
    chk("rst nxt_pc", out_nxt_pc, 0);
    chk("rst upd", out_pc_update_en, 1'b0);
    chk("rst ill", out_illegal, 1'b0);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("rst in_rdy", in_rdy, 1'b1);

    // directed table, one accept per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i]; v.id = 8'(i + 1); v.rd = 6'(i);
      drive(v); in_vld = 1'b1;
      @(posedge clk); #1;
      check_out(v);
    end
    in_vld = 1'b0;
    @(posedge clk); #1;
    chk("drain vld", out_vld, 1'b0);

    // backpressure: output held, requests blocked, accepted on release
    a = tbl[0]; a.id = 8'hA1; b = tbl[1]; b.id = 8'hB2;
    drive(a); in_vld = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0; drive(b);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp in_rdy", in_rdy, 1'b0);
      @(posedge clk); #1;
      check_out(a);
    end
    out_rdy = 1'b1; #1;
    chk("bp release in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    check_out(b);

    // flush with a simultaneous request
    flush = 1'b1; drive(a); #1;
    chk("flush in_rdy", in_rdy, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_vld = 1'b0;
    chk("flush out_vld", out_vld, 1'b0);
    #1 chk("post flush in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    chk("post flush idle", out_vld, 1'b0);

    // random stream with random backpressure
    exp_vld = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = rand_vec(i);
      drive(v);
      in_vld = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !exp_vld || out_rdy;
      chk("rnd in_rdy", in_rdy, exp_rdy);
      acc = in_vld && exp_rdy;
      @(posedge clk); #1;
      if (acc) begin a = v; exp_vld = 1'b1; end
      else if (out_rdy) exp_vld = 1'b0;
      chk("rnd out_vld", out_vld, exp_vld);
      if (exp_vld) check_fields(a);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;

`ifdef TOY_ALU_MUL_EN
    run_mul(32'hFFFF_FFFF, 32'd3, 8'h31);
    run_mul(32'h1234_5678, 32'h9ABC_DEF0, 8'h32);
    // MUL aborted by flush at cycle 10
    v = mk("mulf", OPC_OP, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 3, 0, 0, 0, 0, 0, 0, 4, 0);
    drive(v); in_vld = 1'b1;
    @(posedge clk); #1; in_vld = 1'b0;
    for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    #1 chk("mul flush in_rdy", in_rdy, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_vld) seen = 1'b1;
    end
    chk("mul flush no out_vld", seen, 1'b0);
`endif

    // async reset while a result is held
    a = tbl[0]; a.id = 8'h55; a.rd = 6'd3;
    drive(a); in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; out_rdy = 1'b0;
    chk("pre-rst vld", out_vld, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst vld", out_vld, 1'b0);
    chk("arst data", out_rd_data, 0);
    chk("arst id", out_inst_id, 0);
    chk("arst nxt_pc", out_nxt_pc, 0);
    chk("arst rd_en", out_rd_wr_en, 1'b0);
    @(posedge clk); #1; rst = 1'b0; out_rdy = 1'b1; #1;
    chk("arst in_rdy", in_rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
